note_player: RTL and testbench
==============================

Name: note_player

Overview:
- Consumes note/duration pairs from song_reader and plays each for its duration in beats.
- Returns the one-cycle note_done pulse that song_reader waits on before it issues the next note.
- Converts the 6-bit note number to a phase-increment (frequency step) for the downstream sine/DDS sample stage.
- Emits a registered step on each sample request from that stage.

Parameters:
- BEAT_DIV, 1000: clk cycles per beat (1/48 s in silicon; small values in simulation).
- STEP_W, 20: width of the frequency step, as a fraction of 2^20 per 48 kHz sample.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- play_enable  in  1  1 = playing; 0 = paused
- note_to_load  in  6  note number from song_reader (0 = rest; 1..63 = A0..B5)
- duration_to_load  in  6  duration of the note in beats
- load_new_note  in  1  one-cycle load strobe (song_reader new_note)
- generate_next_sample  in  1  sample request from the DDS stage
- note_done  out  1  one-cycle pulse when the current note expires
- frequency_step  out  STEP_W  phase increment for the current sample
- sample_ready  out  1  one-cycle pulse: frequency_step is valid

Behaviour:
- Reset (reset=0, asynchronous): state IDLE.
  - note_done=0, frequency_step=0, sample_ready=0.
  - Note, duration, remaining-beat and beat counters all cleared.
- States:
  - IDLE: no note. Step source is 0.
  - PLAYING: counting beats.
- load_new_note=1 at a rising edge, from any state:
  - Latch note and duration.
  - remaining = duration, or 1 if duration==0.
  - beat_cnt = 0; state goes to PLAYING.
- In PLAYING with play_enable=1:
  - beat_cnt increments every clk.
  - beat_cnt==BEAT_DIV-1 is a beat tick: beat_cnt wraps to 0 and remaining decrements.
  - The tick that takes remaining from 1 to 0 registers note_done=1 for exactly one cycle and moves the state to IDLE.
  - Resulting latency: note_done is high in the cycle that starts BEAT_DIV*max(duration,1) clk edges after the load edge.
- play_enable=0 (pause):
  - beat_cnt and remaining freeze.
  - Step source is forced to 0.
  - No note_done is generated.
  - Counting resumes from the frozen values when play_enable returns to 1.
- Load in the same cycle as expiry: note_done still pulses; the load wins all registers and the state stays PLAYING with the new note.
- load_new_note while PLAYING: the current note is abandoned without a note_done pulse.
- Step lookup:
  - note 0, IDLE or paused gives step source 0.
  - Otherwise the step comes from the frequency ROM: step = round(f_note * 2^20 / 48000), with f_note = 440 * 2^((n-49)/12).
  - Example: note 49 (A4) = 9612.
- Sample handshake:
  - generate_next_sample=1 at an edge loads frequency_step from the step source and registers sample_ready=1 for the next cycle.
  - frequency_step holds its value between requests.
  - Back-to-back requests are allowed and give back-to-back sample_ready pulses.
- Reset mid-note aborts the note immediately, with no note_done pulse.

Optional Feature:
- Macro: NOTE_PLAYER_RELEASE_EN
- When defined, the last beat of every note with duration>=2 is silent (step source 0) for articulation between repeated notes. Beat counting and note_done timing are unchanged.
- When undefined, the note sounds for its full duration.

Decomposition:
- Package note_player_pkg holds:
  - NOTE_W=6, DUR_W=6, STEP_W default.
  - State encoding enum: IDLE, PLAYING.
  - NOTE_REST=0.
  - The 64-entry step constant table.
- Sub-module frequency_rom: purely combinational, 6-bit note in, STEP_W step out; entry 0 = 0.
- The FSM, beat counter and sample register live in note_player.

Test Plan (all with BEAT_DIV=4):
- Load note 49, duration 3, play_enable=1 -> note_done pulses exactly 12 clk after the load edge, for 1 cycle; a sample request during the note -> frequency_step=9612 with sample_ready one cycle later.
- Load duration 0 -> note_done pulses 4 clk after the load edge; load note 0 (rest) -> frequency_step=0 on sample requests.
- Load duration 2, drop play_enable for 10 cycles mid-note -> note_done delayed by exactly 10 cycles (18 after load); step=0 while paused.
- New load issued on the same edge as expiry -> one note_done pulse, and the new note plays its full duration.
- Assert reset (0) mid-note -> all outputs 0 asynchronously and no note_done; after release, a load plays normally.
- With NOTE_PLAYER_RELEASE_EN, note 49, duration 3 -> step 9612 in beats 1-2 and 0 in beat 3; note_done still at 12 clk.

Source files
------------

// File: rtl/note_player_pkg.sv
// Shared types and constants for the note player: field widths, FSM encoding
// and the note-number to phase-increment table (2^20 fraction per 48 kHz sample).
package note_player_pkg;

  localparam int NOTE_W         = 6;
  localparam int DUR_W          = 6;
  localparam int STEP_W_DEFAULT = 20;

  typedef enum logic {
    IDLE    = 1'b0,
    PLAYING = 1'b1
  } state_t;

  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  // round(440 * 2^((n-49)/12) * 2^20 / 48000); entry 0 is the rest.
  localparam logic [STEP_W_DEFAULT-1:0] STEP_TABLE [64] = '{
    20'd0,     20'd601,   20'd636,   20'd674,   20'd714,   20'd757,   20'd802,   20'd850,
    20'd900,   20'd954,   20'd1010,  20'd1070,  20'd1134,  20'd1201,  20'd1273,  20'd1349,
    20'd1429,  20'd1514,  20'd1604,  20'd1699,  20'd1800,  20'd1907,  20'd2021,  20'd2141,
    20'd2268,  20'd2403,  20'd2546,  20'd2697,  20'd2858,  20'd3028,  20'd3208,  20'd3398,
    20'd3600,  20'd3815,  20'd4041,  20'd4282,  20'd4536,  20'd4806,  20'd5092,  20'd5395,
    20'd5715,  20'd6055,  20'd6415,  20'd6797,  20'd7201,  20'd7629,  20'd8083,  20'd8563,
    20'd9072,  20'd9612,  20'd10184, 20'd10789, 20'd11431, 20'd12110, 20'd12830, 20'd13593,
    20'd14402, 20'd15258, 20'd16165, 20'd17127, 20'd18145, 20'd19224, 20'd20367, 20'd21578
  };

endpackage

// File: rtl/note_player_rom.sv
// Combinational note-number to frequency-step lookup; the rest note maps to 0.
module frequency_rom
  import note_player_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEFAULT
) (
  input  logic [NOTE_W-1:0] note,
  output logic [STEP_W-1:0] step
);

  always_comb begin
    step = '0;
    if (note != NOTE_REST) begin
      step = STEP_W'(STEP_TABLE[note]);
    end
  end

endmodule

// File: rtl/note_player.sv
// Plays note/duration pairs for a number of beats and serves frequency steps to the DDS stage.
// Optional build macro NOTE_PLAYER_RELEASE_EN silences the last beat of notes lasting 2+ beats.
module note_player
  import note_player_pkg::*;
#(
  parameter int BEAT_DIV = 1000,
  parameter int STEP_W   = STEP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic [5:0]        note_to_load,
  input  logic [5:0]        duration_to_load,
  input  logic              load_new_note,
  input  logic              generate_next_sample,
  output logic              note_done,
  output logic [STEP_W-1:0] frequency_step,
  output logic              sample_ready
);

  localparam int              BEAT_W    = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_DIV - 1);

  state_t              state;
  state_t              state_nxt;
  logic [NOTE_W-1:0]   note_q;
  logic [DUR_W-1:0]    remaining;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                counting;
  logic                beat_tick;
  logic                note_expire;
  logic                release_mute;
  logic [STEP_W-1:0]   rom_step;
  logic [STEP_W-1:0]   step_src;

  assign counting    = (state == PLAYING) && play_enable;
  assign beat_tick   = counting && (beat_cnt == BEAT_LAST);
  assign note_expire = beat_tick && (remaining == DUR_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A load always wins, even on the cycle the previous note expires.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (load_new_note) begin
          state_nxt = PLAYING;
        end
      end
      PLAYING: begin
        if (load_new_note) begin
          state_nxt = PLAYING;
        end else if (note_expire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_q    <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      note_done <= 1'b0;
    end else begin
      note_done <= note_expire;
      if (load_new_note) begin
        note_q    <= note_to_load;
        remaining <= (duration_to_load == '0) ? DUR_W'(1) : duration_to_load;
        beat_cnt  <= '0;
      end else if (beat_tick) begin
        beat_cnt  <= '0;
        remaining <= remaining - DUR_W'(1);
      end else if (counting) begin
        beat_cnt  <= beat_cnt + BEAT_W'(1);
      end
    end
  end

`ifdef NOTE_PLAYER_RELEASE_EN
  logic long_note;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      long_note <= 1'b0;
    end else if (load_new_note) begin
      long_note <= (duration_to_load >= DUR_W'(2));
    end
  end

  // remaining==1 marks the final beat of the note.
  assign release_mute = long_note && (remaining == DUR_W'(1));
`else
  assign release_mute = 1'b0;
`endif

  frequency_rom #(
    .STEP_W(STEP_W)
  ) u_rom (
    .note(note_q),
    .step(rom_step)
  );

  always_comb begin
    step_src = '0;
    if (counting && !release_mute) begin
      step_src = rom_step;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frequency_step <= '0;
      sample_ready   <= 1'b0;
    end else begin
      sample_ready <= generate_next_sample;
      if (generate_next_sample) begin
        frequency_step <= step_src;
      end
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player with BEAT_DIV=4: countdown-based reference model plus directed scenarios.
module tb_note_player;

  localparam int BEAT_DIV = 4;
`ifdef NOTE_PLAYER_RELEASE_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        play_enable = 1'b0;
  logic [5:0]  note_to_load = '0;
  logic [5:0]  duration_to_load = '0;
  logic        load_new_note = 1'b0;
  logic        gen = 1'b0;
  logic        note_done;
  logic [19:0] frequency_step;
  logic        sample_ready;

  note_player #(.BEAT_DIV(BEAT_DIV), .STEP_W(20)) dut (
    .clk                 (clk),
    .reset               (rst_n),
    .play_enable         (play_enable),
    .note_to_load        (note_to_load),
    .duration_to_load    (duration_to_load),
    .load_new_note       (load_new_note),
    .generate_next_sample(gen),
    .note_done           (note_done),
    .frequency_step      (frequency_step),
    .sample_ready        (sample_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Equal-tempered pitch straight from the definition, independent of any table.
  function automatic int tbl(input int n);
    real f;
    if (n == 0) return 0;
    f = 440.0 * (2.0 ** ((n - 49) / 12.0));
    return $rtoi(f * 1048576.0 / 48000.0 + 0.5);
  endfunction

  // Model: a note is a budget of enabled clock edges; it ends when the budget runs out.
  logic m_playing = 1'b0;
  int   m_note = 0;
  int   m_left = 0;
  bit   m_long = 1'b0;
  logic exp_done = 1'b0;
  logic exp_ready = 1'b0;
  int   exp_step = 0;
  int   m_src;
  bit   m_mute;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_playing <= 1'b0;
      m_note    <= 0;
      m_left    <= 0;
      m_long    <= 1'b0;
      exp_done  <= 1'b0;
      exp_ready <= 1'b0;
      exp_step  <= 0;
    end else begin
      m_mute = REL && m_long && (m_left <= BEAT_DIV);
      m_src  = (m_playing && play_enable && !m_mute) ? tbl(m_note) : 0;
      exp_ready <= gen;
      if (gen) exp_step <= m_src;
      exp_done <= m_playing && play_enable && (m_left == 1);
      if (load_new_note) begin
        m_playing <= 1'b1;
        m_note    <= int'(note_to_load);
        m_left    <= BEAT_DIV * ((duration_to_load == 0) ? 1 : int'(duration_to_load));
        m_long    <= (duration_to_load >= 2);
      end else if (m_playing && play_enable) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_playing <= 1'b0;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    check("note_done", 32'(note_done), 32'(exp_done));
    check("sample_ready", 32'(sample_ready), 32'(exp_ready));
    check("frequency_step", 32'(frequency_step), exp_step);
    if (note_done) done_q.push_back(cyc);
  end

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic load(input int n, input int d, output int l);
    note_to_load     = 6'(n);
    duration_to_load = 6'(d);
    load_new_note    = 1'b1;
    @(posedge clk);
    #1 l = cyc;
    @(negedge clk);
    load_new_note = 1'b0;
  endtask

  // Request a sample that is taken on the j-th rising edge from now.
  task automatic sample(input int j, input int exp, input string name);
    repeat (j - 1) @(negedge clk);
    gen = 1'b1;
    @(negedge clk);
    gen = 1'b0;
    check({name, "_ready"}, 32'(sample_ready), 1);
    check(name, 32'(frequency_step), exp);
  endtask

  task automatic wait_done(input int cnt, input int l, input int lat, input string name);
    int k;
    k = 0;
    while (done_q.size() < cnt && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (done_q.size() < cnt) check({name, "_timeout"}, done_q.size(), cnt);
    else check(name, done_q[cnt-1] - l, lat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    int l2;
    int cnt;
    int k;

    check("tbl_a4", tbl(49), 9612);
    check("tbl_a0", tbl(1), 601);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(note_done), 0);
    check("rst_ready", 32'(sample_ready), 0);
    check("rst_step", 32'(frequency_step), 0);
    rst_n = 1'b1;
    play_enable = 1'b1;
    @(negedge clk);

    // A4 for three beats
    load(49, 3, l);
    sample(2, 9612, "t1_step");
    wait_done(1, l, 12, "t1_latency");

    // zero duration counts as one beat; then a rest
    load(7, 0, l);
    wait_done(2, l, 4, "t2_latency");
    load(0, 2, l);
    sample(3, 0, "t2_rest_step");
    wait_done(3, l, 8, "t2_rest_latency");

    // ten paused edges in the middle of a two-beat note
    load(40, 2, l);
    repeat (2) @(negedge clk);
    play_enable = 1'b0;
    sample(3, 0, "t3_pause_step");
    repeat (7) @(negedge clk);
    play_enable = 1'b1;
    wait_done(4, l, 18, "t3_latency");

    // load lands on the very edge the previous note expires
    load(49, 1, l);
    k = 0;
    while (cyc < l + 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    load(52, 2, l2);
    sample(2, 11431, "t4_new_step");
    wait_done(5, l, 4, "t4_first_latency");
    wait_done(6, l2, 8, "t4_second_latency");

    // reset in the middle of a note
    load(49, 3, l);
    sample(2, 9612, "t5_step");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_async_done", 32'(note_done), 0);
    check("t5_async_ready", 32'(sample_ready), 0);
    check("t5_async_step", 32'(frequency_step), 0);
    cnt = done_q.size();
    repeat (20) @(negedge clk);
    check("t5_no_done", done_q.size(), cnt);
    rst_n = 1'b1;
    @(negedge clk);
    load(45, 1, l);
    sample(1, 7629, "t5_after_step");
    wait_done(cnt + 1, l, 4, "t5_after_latency");

    // step across the beats of a three-beat note
    load(49, 3, l);
    sample(5, 9612, "t6_beat2_step");
`ifdef NOTE_PLAYER_RELEASE_EN
    sample(5, 0, "t6_beat3_step");
`else
    sample(5, 9612, "t6_beat3_step");
`endif
    wait_done(cnt + 2, l, 12, "t6_latency");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
